// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream to instruction-memory word writer
module imem_loader #(
    parameter int ADDR_W      = 10,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WC_ONE   = (ADDR_W+1)'(1);
    localparam logic [7:0]      HOLD_VAL = 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN, S_ERROR} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_b;
    logic [23:0]       r_partial;
    logic [7:0]        r_hold_cnt;
    logic              r_in_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_word_count;

    logic w_accept;
    logic w_word_done;
    logic w_overflow;
    logic w_bad_last;
    logic w_write;

    assign w_accept    = in_valid && r_in_ready && (r_state == S_LOAD);
    assign w_word_done = w_accept && (r_b == 2'd3);
    assign w_overflow  = w_word_done && (r_word_count == DEPTH);
    assign w_bad_last  = w_accept && in_last && (r_b != 2'd3);
    assign w_write     = w_word_done && !w_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_overflow || w_bad_last) begin
                    w_state_next = S_ERROR;
                end else if (w_word_done && in_last) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == 8'd1) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_ERROR;
        endcase
    end

    // Bytes shift in MSB-first; the 4th byte is appended directly to form the word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_b          <= 2'd0;
            r_partial    <= 24'd0;
            r_hold_cnt   <= 8'd0;
            r_in_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_word_count <= '0;
        end else begin
            r_in_ready <= (w_state_next == S_LOAD);
            r_we       <= w_write;
            if (w_accept) begin
                r_b       <= r_b + 2'd1;
                r_partial <= {r_partial[15:0], in_data};
            end
            if (w_write) begin
                r_addr       <= r_word_count[ADDR_W-1:0];
                r_wdata      <= {r_partial, in_data};
                r_word_count <= r_word_count + WC_ONE;
            end
            if (r_state == S_LOAD && w_state_next == S_HOLD) begin
                r_hold_cnt <= HOLD_VAL;
            end else if (r_state == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign word_count  = r_word_count;
    assign cpu_reset_n = (r_state == S_RUN);
    assign done        = (r_state == S_RUN);
    assign error       = (r_state == S_ERROR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined CPU. It accepts a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words. It writes each word into consecutive instruction-memory word addresses from 0, holding the CPU in reset throughout. It releases the CPU after the final word plus a fixed hold interval, and is the synthesizable counterpart of loading the instruction memory from a hex image.

## Interface

- ADDR_W, 10, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words
- HOLD_CYCLES, 4, cycles cpu_reset_n stays low after the last word is written (1..255)
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock with reset=1 fully reinitialises the block
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_last  in  1  qualifies the final byte of the program; sampled only on acceptance
- in_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the current write
- imem_wdata  out  32  word being written
- cpu_reset_n  out  1  CPU reset, active low (0 = CPU held in reset)
- done  out  1  program loaded and CPU released
- error  out  1  malformed or oversized stream; sticky until reset
- word_count  out  ADDR_W+1  words written so far

## Operation

- Acceptance: a byte is accepted on a rising edge where in_valid && in_ready. A byte is never accepted while in_ready=0.
- Byte packing:
  - 2-bit byte index b starts at 0. Byte b goes to bits [31-8b : 24-8b], so the first byte is the MSB.
  - b increments on each acceptance and wraps 3 -> 0.
- States: LOAD (reset state), HOLD, RUN, ERROR.
- LOAD:
  - in_ready=1, cpu_reset_n=0.
  - Each 4th accepted byte (b=3) completes a word. On that edge, imem_we, imem_addr=word_count and imem_wdata={b0,b1,b2,b3} are registered. word_count increments.
  - Acceptance with b=3 and in_last=1 -> HOLD, after issuing that word's write.
  - Acceptance with in_last=1 and b!=3 -> ERROR. The partial word is discarded and no write is issued.
  - Acceptance that would complete word number DEPTH+1, i.e. word_count==DEPTH at b=3 -> ERROR. No write is issued.
- HOLD:
  - in_ready=0, cpu_reset_n=0.
  - An 8-bit counter loads HOLD_CYCLES on entry and decrements each cycle. At 1 -> RUN.
- RUN: in_ready=0, cpu_reset_n=1, done=1. The block stays here until reset and ignores all inputs.
- ERROR: in_ready=0, cpu_reset_n=0, error=1, imem_we=0. The block stays here until reset.
- Reset values:
  - state=LOAD, b=0, word_count=0.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset_n=0, done=0, error=0.
  - in_ready=0 during the reset cycle, 1 from the first edge after reset deasserts.
- Reset mid-operation: abandons any partial word and restarts at address 0. Words already written stay in memory; a reload overwrites them. Asserting reset in RUN drops cpu_reset_n to 0 on that edge.
- imem_we never asserts in two consecutive cycles, since a word needs at least 4 acceptances.

## Timing

- Let the 4th byte of a word be accepted at edge N.
  - imem_we=1, with imem_addr and imem_wdata valid, for exactly the cycle between edges N and N+1.
  - Memory captures the word at edge N+1.
  - word_count shows the new value after edge N.
- Last word accepted at edge N:
  - state=HOLD after N.
  - cpu_reset_n=1 and done=1 after edge N+HOLD_CYCLES.
  - The final write completes at N+1, before release since HOLD_CYCLES>=1.
- Error detected at edge N: error=1 and in_ready=0 after edge N.
- Continuous in_valid=1 loads one word per 4 cycles; a program of W words releases the CPU 4W+HOLD_CYCLES-1 cycles after the first acceptance edge.
- Gaps in in_valid stall packing without affecting b or the partial word.

## Test plan

- **Single word:** stream 0x8C,0x4F,0x00,0x08 with in_last on the 4th byte.
  - imem_we one cycle, addr 0, wdata 0x8C4F0008, word_count=1.
  - cpu_reset_n and done rise exactly 4 cycles after the last acceptance.
- **Multi-word with gaps:** 3 words (0x01094020, 0xAD5F0008, 0x8D4F0008), in_valid toggled randomly.
  - Writes to addrs 0,1,2 with those values, no extra strobes.
  - in_ready drops after the last byte.
- **Misaligned last:** in_last on the 6th byte.
  - Word 0 written, error=1, no write for the partial word.
  - cpu_reset_n stays 0 and in_ready=0 thereafter.
- **Overflow:** ADDR_W=2, stream 5 words, last flagged on word 5.
  - Addrs 0..3 written, error=1 on the 20th byte, no 5th write.
  - word_count=4.
- **Reset mid-load:** 2 words plus 2 bytes, then reset for one cycle, then 1 word (0xDEADBEEF) with in_last.
  - Write to addr 0 with 0xDEADBEEF, word_count=1, done after HOLD_CYCLES.
- **Reset in RUN:** after done=1, assert reset.
  - cpu_reset_n=0, done=0, in_ready=0 on that edge.
  - in_ready=1 on the following edge; a reload works.
